// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared FSM encoding and widths for the memory stage.
package memory_stage_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO = 2'd1;
    localparam logic [1:0] HI = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    typedef enum logic [1:0] {ST_IDLE = IDLE, ST_LO = LO, ST_HI = HI, ST_DONE = DONE} state_t;
    localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;
    localparam int DATA_W = 32;
    localparam int HALF_W = 16;
endpackage

// File: rtl/memory_stage_sram_half_ctrl.sv
// sram_half_ctrl: holds one half-word transfer on the SRAM pins for WAIT_STATES+1 cycles.
//   start     : a half transfer is in progress (LO or HI)
//   we/half   : write strobe request / selects high half-word
//   addr      : word address; sram_addr = {addr, half}
//   half_done : pulses in the last cycle of the half transfer
module sram_half_ctrl #(
    parameter int WAIT_STATES = 1,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   we,
    input  logic                   half,
    input  logic [SRAM_ADDR_W-2:0] addr,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic                   half_done
);
    logic [3:0] cnt;
    assign half_done = start && cnt == 4'(WAIT_STATES);
    assign sram_addr = start ? {addr, half} : '0;
    assign sram_we_n = !(start && we);
    always_ff @(posedge clk)
        cnt <= (rst || !start || half_done) ? '0 : cnt + 4'd1;
endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage doing 32-bit LDR/STR as two half-words on a 16-bit async SRAM.
//   Pass-through: destination, aluResult, memoryReadEnabled, writeBackEnabled.
//   data: loaded word, updated when a read completes; ready: 0 stalls the whole pipeline.
//   sram_addr/sram_wdata/sram_rdata/sram_we_n: SRAM pins.
//   MEMORY_STAGE_PERF_COUNTERS_EN adds readCount, writeCount, stallCycles.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int          WAIT_STATES = 1,
    parameter int          SRAM_ADDR_W = 18,
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             destination_in,
    input  logic [31:0]            aluResult_in,
    input  logic [31:0]            storeData_in,
    input  logic                   memoryReadEnabled_in,
    input  logic                   memoryWriteEnabled_in,
    input  logic                   writeBackEnabled_in,
    output logic [3:0]             destination,
    output logic [31:0]            aluResult,
    output logic                   memoryReadEnabled,
    output logic                   writeBackEnabled,
    output logic [DATA_W-1:0]      data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [HALF_W-1:0]      sram_wdata,
    input  logic [HALF_W-1:0]      sram_rdata,
    output logic                   sram_we_n
`ifdef MEMORY_STAGE_PERF_COUNTERS_EN
    ,
    output logic [31:0]            readCount,
    output logic [31:0]            writeCount,
    output logic [31:0]            stallCycles
`endif
);
    state_t state, state_nx;
    logic request, is_write, busy, half_done;
    logic [SRAM_ADDR_W-2:0] word;
    logic [HALF_W-1:0] lo_q;
    assign destination = destination_in;
    assign aluResult = aluResult_in;
    assign memoryReadEnabled = memoryReadEnabled_in;
    assign writeBackEnabled = writeBackEnabled_in;
    // write wins when both strobes are set
    assign request = memoryReadEnabled_in | memoryWriteEnabled_in;
    assign is_write = memoryWriteEnabled_in;
    assign busy = state == ST_LO || state == ST_HI;
    assign ready = !(request && state != ST_DONE);
    assign word = (SRAM_ADDR_W-1)'((aluResult_in - MEM_BASE) >> 2);
    assign sram_wdata = !(busy && is_write) ? '0 : state == ST_HI ? storeData_in[31:16] : storeData_in[15:0];
    sram_half_ctrl #(.WAIT_STATES(WAIT_STATES), .SRAM_ADDR_W(SRAM_ADDR_W)) u_half (
        .clk(clk), .rst(rst), .start(busy), .we(is_write), .half(state == ST_HI),
        .addr(word), .sram_addr(sram_addr), .sram_we_n(sram_we_n), .half_done(half_done)
    );
    always_comb
        state_nx = state == ST_IDLE ? (request ? ST_LO : ST_IDLE)
                 : state == ST_LO ? (half_done ? ST_HI : ST_LO)
                 : state == ST_HI ? (half_done ? ST_DONE : ST_HI)
                 : ST_IDLE;
    always_ff @(posedge clk)
        state <= rst ? ST_IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '0;
            data <= '0;
        end else if (half_done && !is_write) begin
            if (state == ST_LO) lo_q <= sram_rdata;
            else data <= {sram_rdata, lo_q};
        end
    end
`ifdef MEMORY_STAGE_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            readCount <= '0;
            writeCount <= '0;
            stallCycles <= '0;
        end else begin
            readCount <= readCount + 32'(state == ST_DONE && memoryReadEnabled_in && !is_write);
            writeCount <= writeCount + 32'(state == ST_DONE && is_write);
            stallCycles <= stallCycles + 32'(!ready);
        end
    end
`endif
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: random + directed checks of memory_stage against a transaction-level model.
module tb_memory_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] wordof(input logic [31:0] a);
        return (a - 32'd1024) >> 2;
    endfunction
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int W = g == 0 ? 1 : 0;
        localparam int L = 2 * W + 3;
        localparam int STALL_LIT = g == 0 ? 5 : 3;
        localparam int WE_LIT = g == 0 ? 4 : 2;
        logic rst, init, rd, wr, wb, fin = 1'b0;
        logic [3:0] dst, destination;
        logic [31:0] alu, sd, aluResult, data;
        logic mre, wbe, ready, sram_we_n;
        logic [17:0] sram_addr, run_addr;
        logic [15:0] sram_wdata, sram_rdata;
        logic [15:0] mem [0:31];
        logic [15:0] refh [0:31];
        logic [31:0] exp_data;
        int run = 0;
        int k = 0;
`ifdef MEMORY_STAGE_PERF_COUNTERS_EN
        logic [31:0] rc, wc, sc;
`endif
        memory_stage #(.WAIT_STATES(W)) dut (
            .clk(clk), .rst(rst), .destination_in(dst), .aluResult_in(alu), .storeData_in(sd),
            .memoryReadEnabled_in(rd), .memoryWriteEnabled_in(wr), .writeBackEnabled_in(wb),
            .destination(destination), .aluResult(aluResult), .memoryReadEnabled(mre),
            .writeBackEnabled(wbe), .data(data), .ready(ready), .sram_addr(sram_addr),
            .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_we_n(sram_we_n)
`ifdef MEMORY_STAGE_PERF_COUNTERS_EN
            , .readCount(rc), .writeCount(wc), .stallCycles(sc)
`endif
        );
        // SRAM device: a write lands only once the strobe has been held W+1 cycles on one address
        assign sram_rdata = mem[sram_addr[4:0]];
        always @(posedge clk) begin
            if (init) begin
                for (int i = 0; i < 32; i++) mem[i] <= 16'(i * 257 + 16'h3c00);
            end else if (sram_we_n) begin
                run <= 0;
            end else begin
                run <= (run != 0 && sram_addr == run_addr) ? run + 1 : 1;
                run_addr <= sram_addr;
                if (((run != 0 && sram_addr == run_addr) ? run + 1 : 1) == W + 1)
                    mem[sram_addr[4:0]] <= sram_wdata;
            end
        end
        // model: k = cycles elapsed since the request appeared; L is the DONE cycle
        always @(posedge clk) begin
            if (init) begin
                for (int i = 0; i < 32; i++) refh[i] <= 16'(i * 257 + 16'h3c00);
                k <= 0;
                exp_data <= 0;
            end else if (rst) begin
                if (wr && k >= W + 2) refh[5'(2 * wordof(alu))] <= sd[15:0];
                if (wr && k == 2 * W + 2) refh[5'(2 * wordof(alu) + 1)] <= sd[31:16];
                k <= 0;
                exp_data <= 0;
            end else if (rd || wr) begin
                k <= k == L ? 0 : k + 1;
                if (k == 2 * W + 2 && wr) begin
                    refh[5'(2 * wordof(alu))] <= sd[15:0];
                    refh[5'(2 * wordof(alu) + 1)] <= sd[31:16];
                end
                if (k == 2 * W + 2 && !wr)
                    exp_data <= {refh[5'(2 * wordof(alu) + 1)], refh[5'(2 * wordof(alu))]};
            end else begin
                k <= 0;
            end
        end
        always @(negedge clk) begin : cmp
            bit xfer;
            int half;
            if (!init && !rst) begin
                xfer = (rd || wr) && k >= 1 && k <= 2 * W + 2;
                half = (k - 1) / (W + 1);
                check($sformatf("W%0d destination", W), 32'(destination), 32'(dst));
                check($sformatf("W%0d aluResult", W), aluResult, alu);
                check($sformatf("W%0d memoryReadEnabled", W), 32'(mre), 32'(rd));
                check($sformatf("W%0d writeBackEnabled", W), 32'(wbe), 32'(wb));
                check($sformatf("W%0d ready k=%0d", W, k), 32'(ready), 32'(!(rd || wr) || k == L));
                check($sformatf("W%0d we_n k=%0d", W, k), 32'(sram_we_n), 32'(!(xfer && wr)));
                check($sformatf("W%0d sram_addr k=%0d", W, k), 32'(sram_addr), xfer ? 2 * wordof(alu) + 32'(half) : 0);
                if (xfer && wr)
                    check($sformatf("W%0d sram_wdata k=%0d", W, k), 32'(sram_wdata), 32'(half != 0 ? sd[31:16] : sd[15:0]));
                check($sformatf("W%0d data", W), data, exp_data);
            end
        end
        task automatic randomize_side();
            dst = 4'($urandom);
            wb = 1'($urandom);
        endtask
        task automatic op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output int stall, output int wel);
            randomize_side();
            alu = a;
            sd = d;
            rd = r;
            wr = w;
            stall = 0;
            wel = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (ready) break;
                stall++;
                if (!sram_we_n) wel++;
            end
            @(posedge clk);
            #1;
            rd = 0;
            wr = 0;
            alu = $urandom;
            sd = $urandom;
        endtask
        task automatic idle(input int n);
            for (int i = 0; i < n; i++) begin
                randomize_side();
                alu = $urandom;
                sd = $urandom;
                @(posedge clk);
                #1;
            end
        endtask
        initial begin
            int s, we, kind, found;
            logic [31:0] a;
            rst = 1; init = 1; rd = 0; wr = 0; wb = 0; dst = 0; alu = 0; sd = 0;
            @(posedge clk); #1 init = 0;
            @(posedge clk); #1 rst = 0;
            @(negedge clk);
            check($sformatf("W%0d reset ready", W), 32'(ready), 1);
            check($sformatf("W%0d reset we_n", W), 32'(sram_we_n), 1);
            check($sformatf("W%0d reset sram_addr", W), 32'(sram_addr), 0);
            check($sformatf("W%0d reset data", W), data, 0);
            @(posedge clk); #1;
            op(1, 0, 32'd1024 + 32, 0, s, we);
            check($sformatf("W%0d b2b read stall", W), s, STALL_LIT);
            op(0, 1, 32'd1024 + 36, 32'h0bad_cafe, s, we);
            check($sformatf("W%0d b2b write stall", W), s, STALL_LIT);
`ifdef MEMORY_STAGE_PERF_COUNTERS_EN
            check($sformatf("W%0d readCount", W), rc, 1);
            check($sformatf("W%0d writeCount", W), wc, 1);
            check($sformatf("W%0d stallCycles", W), sc, 2 * STALL_LIT);
`endif
            op(0, 1, 32'd1024, 32'hdead_beef, s, we);
            check($sformatf("W%0d write stall", W), s, STALL_LIT);
            check($sformatf("W%0d write we_n low", W), we, WE_LIT);
            check($sformatf("W%0d SRAM[0]", W), 32'(mem[0]), 32'h0000_beef);
            check($sformatf("W%0d SRAM[1]", W), 32'(mem[1]), 32'h0000_dead);
            op(0, 1, 32'd1028, 32'h1234_5678, s, we);
            check($sformatf("W%0d SRAM[2]", W), 32'(mem[2]), 32'h0000_5678);
            check($sformatf("W%0d SRAM[3]", W), 32'(mem[3]), 32'h0000_1234);
            op(1, 0, 32'd1028, $urandom, s, we);
            check($sformatf("W%0d read data", W), data, 32'h1234_5678);
            idle(10);
            @(negedge clk);
            check($sformatf("W%0d idle ready", W), 32'(ready), 1);
            check($sformatf("W%0d idle data", W), data, 32'h1234_5678);
            @(posedge clk); #1;
            op(1, 1, 32'd1032, 32'ha5a5_0f0f, s, we);
            check($sformatf("W%0d both SRAM[4]", W), 32'(mem[4]), 32'h0000_0f0f);
            check($sformatf("W%0d both SRAM[5]", W), 32'(mem[5]), 32'h0000_a5a5);
            check($sformatf("W%0d both data", W), data, 32'h1234_5678);
            if (W >= 1) begin
                randomize_side();
                rd = 0; wr = 1; alu = 32'd1024; sd = 32'hcafe_0001;
                found = 0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    if (!sram_we_n && sram_addr[0]) begin
                        found = 1;
                        break;
                    end
                end
                check($sformatf("W%0d reached HI", W), found, 1);
                rst = 1;
                @(posedge clk); #1;
                rst = 0;
                wr = 0;
                @(negedge clk);
                check($sformatf("W%0d rst-mid ready", W), 32'(ready), 1);
                check($sformatf("W%0d rst-mid we_n", W), 32'(sram_we_n), 1);
                check($sformatf("W%0d rst-mid sram_addr", W), 32'(sram_addr), 0);
                check($sformatf("W%0d rst-mid data", W), data, 0);
                check($sformatf("W%0d rst-mid SRAM[0]", W), 32'(mem[0]), 32'h0000_0001);
                check($sformatf("W%0d rst-mid SRAM[1]", W), 32'(mem[1]), 32'h0000_dead);
                @(posedge clk); #1;
            end
            repeat (60) begin
                kind = $urandom_range(0, 3);
                a = 32'd1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                if (kind == 0) idle($urandom_range(1, 3));
                else begin
                    op(kind != 2, kind >= 2, a, $urandom, s, we);
                    check($sformatf("W%0d random stall", W), s, L);
                end
            end
            for (int i = 0; i < 32; i++)
                check($sformatf("W%0d final SRAM[%0d]", W, i), 32'(mem[i]), 32'(refh[i]));
            fin = 1;
        end
    end
    initial begin
        for (int i = 0; i < 20000 && !(u[0].fin && u[1].fin); i++) @(posedge clk);
        check("all sequences finished", 32'({u[0].fin, u[1].fin}), 32'b11);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
